// File: rtl/baccarat_sequencer.sv
// baccarat_sequencer: Moore FSM sequencing card loads and win lights for one baccarat hand.
// Rev 1.0 - initial release.
`default_nettype none

module baccarat_sequencer (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  localparam logic [3:0] ST_RST  = 4'd0;
  localparam logic [3:0] ST_DP1  = 4'd1;
  localparam logic [3:0] ST_DD1  = 4'd2;
  localparam logic [3:0] ST_DP2  = 4'd3;
  localparam logic [3:0] ST_DD2  = 4'd4;
  localparam logic [3:0] ST_EVAL = 4'd5;
  localparam logic [3:0] ST_DP3  = 4'd6;
  localparam logic [3:0] ST_DD3  = 4'd7;
  localparam logic [3:0] ST_DONE = 4'd8;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] pval;
  logic       banker_draws;

  // Tens and face cards count as zero toward the banker's third-card rule.
  assign pval = (pcard3 <= 4'd9) ? pcard3 : 4'd0;

  always_comb begin
    banker_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (pval != 4'd8);
      4'd4:             banker_draws = (pval >= 4'd2) && (pval <= 4'd7);
      4'd5:             banker_draws = (pval >= 4'd4) && (pval <= 4'd7);
      4'd6:             banker_draws = (pval >= 4'd6) && (pval <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:  state_nxt = ST_DP1;
      ST_DP1:  state_nxt = ST_DD1;
      ST_DD1:  state_nxt = ST_DP2;
      ST_DP2:  state_nxt = ST_DD2;
      ST_DD2:  state_nxt = ST_EVAL;
      ST_EVAL: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8))
          state_nxt = ST_DONE;
        else if (pscore <= 4'd5)
          state_nxt = ST_DP3;
        else if (dscore <= 4'd5)
          state_nxt = ST_DD3;
        else
          state_nxt = ST_DONE;
      end
      ST_DP3:  state_nxt = banker_draws ? ST_DD3 : ST_DONE;
      ST_DD3:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_RST;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb)
      state <= ST_RST;
    else
      state <= state_nxt;
  end

  assign load_pcard1 = (state == ST_DP1);
  assign load_dcard1 = (state == ST_DD1);
  assign load_pcard2 = (state == ST_DP2);
  assign load_dcard2 = (state == ST_DD2);
  assign load_pcard3 = (state == ST_DP3);
  assign load_dcard3 = (state == ST_DD3);

  assign player_win_light = (state == ST_DONE) && (pscore >= dscore);
  assign dealer_win_light = (state == ST_DONE) && (dscore >= pscore);

endmodule

`default_nettype wire

// File: tb/tb_baccarat_sequencer.sv
// tb_baccarat_sequencer: directed self-checking bench for baccarat_sequencer.
// Rev 1.0 - initial release.
`default_nettype none

module tb_baccarat_sequencer;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;

  int total;
  int bad;

  baccarat_sequencer dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  // Output vector order: {lp1, ld1, lp2, ld2, lp3, ld3, pwin, dwin}
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_DP1  = 8'b1000_0000;
  localparam logic [7:0] O_DD1  = 8'b0100_0000;
  localparam logic [7:0] O_DP2  = 8'b0010_0000;
  localparam logic [7:0] O_DD2  = 8'b0001_0000;
  localparam logic [7:0] O_DP3  = 8'b0000_1000;
  localparam logic [7:0] O_DD3  = 8'b0000_0100;
  localparam logic [7:0] O_PW   = 8'b0000_0010;
  localparam logic [7:0] O_DW   = 8'b0000_0001;
  localparam logic [7:0] O_TIE  = 8'b0000_0011;

  function automatic logic [7:0] outs();
    return {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
            load_pcard3, load_dcard3, player_win_light, dealer_win_light};
  endfunction

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    observed = outs();
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Reset one cycle, release, and walk the four fixed deal states into EVAL.
  task automatic deal_to_eval(input string tag);
    resetb = 1'b0;
    step();
    check({tag, "_rst"}, O_NONE);
    resetb = 1'b1;
    step(); check({tag, "_dp1"}, O_DP1);
    step(); check({tag, "_dd1"}, O_DD1);
    step(); check({tag, "_dp2"}, O_DP2);
    step(); check({tag, "_dd2"}, O_DD2);
    step(); check({tag, "_eval"}, O_NONE);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetb = 1'b0;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;
    step();
    step();
    check("reset_hold", O_NONE);

    // Natural: player 8 beats dealer 3, no third cards.
    deal_to_eval("nat");
    pscore = 4'd8; dscore = 4'd3;
    step(); check("nat_done", O_PW);
    step(); check("nat_terminal", O_PW);

    // Player draws, dealer draws on 6 vs 7.
    deal_to_eval("pd");
    pscore = 4'd4; dscore = 4'd6;
    step(); check("pd_dp3", O_DP3);
    pcard3 = 4'd7; dscore = 4'd6;
    step(); check("pd_dd3", O_DD3);
    pscore = 4'd1; dscore = 4'd6;
    step(); check("pd_done", O_DW);

    // Face card counts zero: dealer 4 stands.
    deal_to_eval("face");
    pscore = 4'd2; dscore = 4'd4;
    step(); check("face_dp3", O_DP3);
    pcard3 = 4'd12; dscore = 4'd4;
    step(); check("face_done", O_DW);

    // Dealer 3 stands on an 8.
    deal_to_eval("d3v8");
    pscore = 4'd2; dscore = 4'd3;
    step(); check("d3v8_dp3", O_DP3);
    pcard3 = 4'd8;
    step(); check("d3v8_done", O_DW);

    // Dealer 5 draws on a 4.
    deal_to_eval("d5v4");
    pscore = 4'd5; dscore = 4'd5;
    step(); check("d5v4_dp3", O_DP3);
    pcard3 = 4'd4;
    step(); check("d5v4_dd3", O_DD3);
    pscore = 4'd9; dscore = 4'd2;
    step(); check("d5v4_done", O_PW);

    // Dealer 7 always stands after player draw.
    deal_to_eval("d7");
    pscore = 4'd3; dscore = 4'd7;
    step(); check("d7_dp3", O_DP3);
    pcard3 = 4'd6;
    step(); check("d7_done", O_DW);

    // Player stands on 6, dealer 5 draws directly; tie.
    deal_to_eval("stand");
    pscore = 4'd6; dscore = 4'd5;
    step(); check("stand_dd3", O_DD3);
    pscore = 4'd6; dscore = 4'd6;
    step(); check("stand_tie", O_TIE);

    // Both stand: player 7, dealer 6.
    deal_to_eval("both");
    pscore = 4'd7; dscore = 4'd6;
    step(); check("both_done", O_PW);

    // Dealer natural 9 ends the hand even with player at 2.
    deal_to_eval("dnat");
    pscore = 4'd2; dscore = 4'd9;
    step(); check("dnat_done", O_DW);

    // Reset in the middle of the deal.
    resetb = 1'b0;
    step(); check("mid_rst_hold", O_NONE);
    resetb = 1'b1;
    step(); check("mid_dp1", O_DP1);
    step(); check("mid_dd1", O_DD1);
    step(); check("mid_dp2", O_DP2);
    step(); check("mid_dd2", O_DD2);
    resetb = 1'b0;
    step(); check("mid_rst1", O_NONE);
    step(); check("mid_rst2", O_NONE);
    step(); check("mid_rst3", O_NONE);
    resetb = 1'b1;
    step(); check("mid_restart_dp1", O_DP1);
    step(); check("mid_restart_dd1", O_DD1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/baccarat_sequencer.md
BACCARAT_SEQUENCER -- requirements
Module: baccarat_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths and encodings are fixed.
REQ-002 slow_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetb  input  1  reset, synchronous and active-low, sampled on the rising edge of slow_clock.
REQ-004 pscore  input  4  player hand score from datapath, 0-9.
REQ-005 dscore  input  4  dealer hand score from datapath, 0-9.
REQ-006 pcard3  input  4  player third-card code: 0 none, 1 ace, 2-10 pips, 11-13 J/Q/K.
REQ-007 load_pcard1, load_pcard2, load_pcard3  output  1 each  player card-register load enables.
REQ-008 load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card-register load enables.
REQ-009 player_win_light  output  1  player wins, or tie.
REQ-010 dealer_win_light  output  1  dealer wins, or tie.

Function
REQ-011 The block SHALL be a Moore FSM with states RST, DP1, DD1, DP2, DD2, EVAL, DP3, DD3 and DONE.
REQ-012 Each load output SHALL depend only on the current state and SHALL be high for exactly one slow_clock cycle:
- DP1 -> load_pcard1
- DD1 -> load_dcard1
- DP2 -> load_pcard2
- DD2 -> load_dcard2
- DP3 -> load_pcard3
- DD3 -> load_dcard3
- all other loads 0.
REQ-013 At most one load output SHALL be high in any cycle.
REQ-014 The datapath captures on the falling edge, so a card loaded in state X SHALL be reflected in pscore, dscore and pcard3 at the rising edge that leaves X; transition decisions SHALL use the input values at that edge.
REQ-015 Fixed transitions:
- RST -> DP1 -> DD1 -> DP2 -> DD2 -> EVAL.
REQ-016 EVAL exit rule 1: if pscore >= 8 or dscore >= 8 (natural), go to DONE.
REQ-017 EVAL exit rule 2: otherwise, if pscore <= 5, go to DP3.
REQ-018 EVAL exit rule 3: otherwise (player stands on 6-7), go to DD3 if dscore <= 5, else DONE.
REQ-019 DP3 exit: compute v = pcard3 if pcard3 <= 9, else 0. Go to DD3 when any of these holds, else DONE:
- dscore <= 2
- dscore = 3 and v != 8
- dscore = 4 and 2 <= v <= 7
- dscore = 5 and 4 <= v <= 7
- dscore = 6 and 6 <= v <= 7
REQ-020 dscore = 7 at DP3 exit SHALL always lead to DONE.
REQ-021 DD3 SHALL always go to DONE.
REQ-022 DONE SHALL be terminal; the block leaves it only via reset.
REQ-023 In DONE the lights SHALL be:
- player_win_light = (pscore >= dscore)
- dealer_win_light = (dscore >= pscore)
- both high on a tie.
REQ-024 Both lights SHALL be 0 in every state other than DONE.
REQ-025 Score comparisons SHALL be unsigned 4-bit; input values above 9 need no defined behaviour.

Reset
REQ-026 When resetb = 0 at a rising edge, the state SHALL become RST regardless of current state, including mid-deal and DONE.
REQ-027 In RST, all six load outputs and both lights SHALL be 0.
REQ-028 While resetb stays 0, the block SHALL remain in RST; the first rising edge with resetb = 1 SHALL move it to DP1.

Verification
REQ-029 Deal sequence: release reset -> load_pcard1, load_dcard1, load_pcard2, load_dcard2 each high one cycle in that order, then EVAL with no load.
REQ-030 Natural: at EVAL exit pscore=8, dscore=3 -> DONE next cycle, no third-card loads, player_win_light=1, dealer_win_light=0.
REQ-031 Player draws, dealer draws: EVAL pscore=4, dscore=6 -> DP3 (load_pcard3); at DP3 exit pcard3=7, dscore=6 -> DD3 (load_dcard3) -> DONE; with pscore=1, dscore=6 -> dealer_win_light=1 only.
REQ-032 Face card as zero: EVAL pscore=2, dscore=4 -> DP3; pcard3=12 (v=0), dscore=4 -> DONE without load_dcard3. Also dscore=3, pcard3=8 -> DONE without load_dcard3.
REQ-033 Player stands: EVAL pscore=6, dscore=5 -> DD3 directly, no load_pcard3; then pscore=6, dscore=6 -> both lights 1.
REQ-034 Reset mid-operation: resetb=0 during DD2 -> RST next edge, all outputs 0; held 3 cycles -> still RST; released -> DP1, sequence restarts.
